// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register, DR select decode and TDO mux.
// Optional usercode data register is built when TAP_USERCODE_EN is defined.
module tap_controller #(
  parameter int                  IR_WIDTH       = 4,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR   = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] USERCODE_INSTR = IR_WIDTH'(2),
  parameter logic [31:0]         USERCODE_VALUE = 32'h0000_0000
) (
  input  logic                tck,
  input  logic                reset,
  input  logic                tms,
  input  logic                tdi,
  input  logic                idcode_tdo,
  output logic                tdo,
  output logic                tdo_en,
  output logic                captureDR,
  output logic                shiftDR,
  output logic                updateDR,
  output logic                select_idcode,
  output logic                select_bypass,
  output logic                select_usercode,
  output logic [IR_WIDTH-1:0] instruction,
  output logic [3:0]          tap_state
);

  typedef enum logic [3:0] {
    S_TLR     = 4'hF, S_RTI     = 4'hC,
    S_SEL_DR  = 4'h7, S_CAP_DR  = 4'h6, S_SH_DR   = 4'h2, S_EX1_DR  = 4'h1,
    S_PAU_DR  = 4'h3, S_EX2_DR  = 4'h0, S_UPD_DR  = 4'h5,
    S_SEL_IR  = 4'h4, S_CAP_IR  = 4'hE, S_SH_IR   = 4'hA, S_EX1_IR  = 4'h9,
    S_PAU_IR  = 4'hB, S_EX2_IR  = 4'h8, S_UPD_IR  = 4'hD
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  tap_state_t            r_state;
  tap_state_t            w_state_next;
  logic [IR_WIDTH-1:0]   r_ir_sr;
  logic [IR_WIDTH-1:0]   r_instruction;
  logic                  r_bypass;
  logic                  r_tdo;
  logic                  r_tdo_en;
  logic                  w_tdo_mux;
  logic                  w_shifting;
  logic                  w_sel_idcode;
  logic                  w_sel_usercode;
  logic                  w_sel_bypass;
  logic                  w_uc_lsb;

  always_ff @(posedge tck) begin
    if (reset) r_state <= S_TLR;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = S_TLR;
    case (r_state)
      S_TLR:    w_state_next = tms ? S_TLR    : S_RTI;
      S_RTI:    w_state_next = tms ? S_SEL_DR : S_RTI;
      S_SEL_DR: w_state_next = tms ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: w_state_next = tms ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  w_state_next = tms ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: w_state_next = tms ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: w_state_next = tms ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: w_state_next = tms ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: w_state_next = tms ? S_SEL_DR : S_RTI;
      S_SEL_IR: w_state_next = tms ? S_TLR    : S_CAP_IR;
      S_CAP_IR: w_state_next = tms ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  w_state_next = tms ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: w_state_next = tms ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: w_state_next = tms ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: w_state_next = tms ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: w_state_next = tms ? S_SEL_DR : S_RTI;
      default:  w_state_next = S_TLR;
    endcase
  end

  // Instruction falls back to IDCODE on the edge that enters TLR, so it is valid while in TLR.
  always_ff @(posedge tck) begin
    if (reset) begin
      r_ir_sr       <= IR_CAPTURE;
      r_instruction <= IDCODE_INSTR;
    end else begin
      if (r_state == S_CAP_IR)     r_ir_sr <= IR_CAPTURE;
      else if (r_state == S_SH_IR) r_ir_sr <= {tdi, r_ir_sr[IR_WIDTH-1:1]};
      if (w_state_next == S_TLR)   r_instruction <= IDCODE_INSTR;
      else if (r_state == S_UPD_IR) r_instruction <= r_ir_sr;
    end
  end

  assign w_sel_idcode = (r_instruction == IDCODE_INSTR);

`ifdef TAP_USERCODE_EN
  logic [31:0] r_usercode;

  assign w_sel_usercode = !w_sel_idcode && (r_instruction == USERCODE_INSTR);

  always_ff @(posedge tck) begin
    if (reset) begin
      r_usercode <= USERCODE_VALUE;
    end else if (w_sel_usercode) begin
      if (r_state == S_CAP_DR)     r_usercode <= USERCODE_VALUE;
      else if (r_state == S_SH_DR) r_usercode <= {tdi, r_usercode[31:1]};
    end
  end

  assign w_uc_lsb = r_usercode[0];
`else
  assign w_sel_usercode = 1'b0;
  assign w_uc_lsb       = 1'b0;
`endif

  assign w_sel_bypass = !w_sel_idcode && !w_sel_usercode;

  always_ff @(posedge tck) begin
    if (reset) begin
      r_bypass <= 1'b0;
    end else if (w_sel_bypass) begin
      if (r_state == S_CAP_DR)     r_bypass <= 1'b0;
      else if (r_state == S_SH_DR) r_bypass <= tdi;
    end
  end

  assign w_shifting = (r_state == S_SH_IR) || (r_state == S_SH_DR);

  always_comb begin
    w_tdo_mux = 1'b0;
    if (r_state == S_SH_IR) begin
      w_tdo_mux = r_ir_sr[0];
    end else if (r_state == S_SH_DR) begin
      if (w_sel_idcode)        w_tdo_mux = idcode_tdo;
      else if (w_sel_usercode) w_tdo_mux = w_uc_lsb;
      else                     w_tdo_mux = r_bypass;
    end
  end

  // TDO launches on the falling edge so the far end can sample it on the next rising edge.
  always_ff @(negedge tck) begin
    if (reset) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo    <= w_tdo_mux;
      r_tdo_en <= w_shifting;
    end
  end

  assign tdo             = r_tdo;
  assign tdo_en          = r_tdo_en;
  assign captureDR       = (r_state == S_CAP_DR);
  assign shiftDR         = (r_state == S_SH_DR);
  assign updateDR        = (r_state == S_UPD_DR);
  assign select_idcode   = w_sel_idcode;
  assign select_bypass   = w_sel_bypass;
  assign select_usercode = w_sel_usercode;
  assign instruction     = r_instruction;
  assign tap_state       = r_state;

endmodule

// File: tb/tb_tap_controller.sv
// Directed bench for tap_controller with an attached 32-bit device ID register model.
module tb_tap_controller;

  localparam logic [31:0] ID_VALUE = 32'h4BA0_0477;
  localparam logic [31:0] UC_VALUE = 32'hCAFE_F00D;
  localparam logic [31:0] TDI_PAT  = 32'h1234_5678;

  logic       tck = 1'b0;
  logic       reset, tms, tdi;
  logic       idcode_tdo;
  logic       tdo, tdo_en, captureDR, shiftDR, updateDR;
  logic       select_idcode, select_bypass, select_usercode;
  logic [3:0] instruction;
  logic [3:0] tap_state;
  logic [31:0] id_reg;

  int n_checks = 0;
  int n_pass   = 0;

  tap_controller #(
    .IR_WIDTH(4), .IDCODE_INSTR(4'b0001), .USERCODE_INSTR(4'b0010), .USERCODE_VALUE(UC_VALUE)
  ) dut (
    .tck(tck), .reset(reset), .tms(tms), .tdi(tdi), .idcode_tdo(idcode_tdo),
    .tdo(tdo), .tdo_en(tdo_en), .captureDR(captureDR), .shiftDR(shiftDR), .updateDR(updateDR),
    .select_idcode(select_idcode), .select_bypass(select_bypass), .select_usercode(select_usercode),
    .instruction(instruction), .tap_state(tap_state)
  );

  always #5 tck = ~tck;

  // External ID register, enabled by the controller strobes.
  always @(posedge tck) begin
    if (captureDR && select_idcode)    id_reg <= ID_VALUE;
    else if (shiftDR && select_idcode) id_reg <= {tdi, id_reg[31:1]};
  end
  assign idcode_tdo = id_reg[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input logic t_ms, input logic t_di);
    tms = t_ms;
    tdi = t_di;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic load_ir(input logic [3:0] op);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(i == 3, op[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    step(1'b0, 1'b0);
  endtask

  string      paths [16];
  logic [3:0] targets [16];
  int         en_count;
  logic [31:0] exp_bit;

  initial begin
    paths[0]  = "111";    targets[0]  = 4'hF;
    paths[1]  = "";       targets[1]  = 4'hC;
    paths[2]  = "1";      targets[2]  = 4'h7;
    paths[3]  = "10";     targets[3]  = 4'h6;
    paths[4]  = "100";    targets[4]  = 4'h2;
    paths[5]  = "101";    targets[5]  = 4'h1;
    paths[6]  = "1010";   targets[6]  = 4'h3;
    paths[7]  = "10101";  targets[7]  = 4'h0;
    paths[8]  = "1011";   targets[8]  = 4'h5;
    paths[9]  = "11";     targets[9]  = 4'h4;
    paths[10] = "110";    targets[10] = 4'hE;
    paths[11] = "1100";   targets[11] = 4'hA;
    paths[12] = "1101";   targets[12] = 4'h9;
    paths[13] = "11010";  targets[13] = 4'hB;
    paths[14] = "110101"; targets[14] = 4'h8;
    paths[15] = "11011";  targets[15] = 4'hD;

    reset = 1'b1; tms = 1'b1; tdi = 1'b0;
    step(1'b0, 1'b0);
    check("reset_state", {28'd0, tap_state}, 32'hF);
    check("reset_tdo_en", {31'd0, tdo_en}, 32'd0);
    reset = 1'b0;
    step(1'b0, 1'b0);
    check("rti_state", {28'd0, tap_state}, 32'hC);
    check("rti_instr", {28'd0, instruction}, 32'h1);
    check("rti_sel_id", {29'd0, select_idcode, select_bypass, select_usercode}, 32'b100);
    check("rti_tdo_en", {31'd0, tdo_en}, 32'd0);

    // IDCODE scan, 32 bits LSB-first
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("capdr_strobe", {30'd0, captureDR, shiftDR}, 32'b10);
    step(1'b0, 1'b0);
    check("shdr_strobe", {30'd0, captureDR, shiftDR}, 32'b01);
    en_count = 0;
    if (tdo_en) en_count++;
    check("id_bit0", {31'd0, tdo}, {31'd0, ID_VALUE[0]});
    for (int k = 1; k <= 32; k++) begin
      step(k == 32, 1'b0);
      if (tdo_en) en_count++;
      if (k < 32) check($sformatf("id_bit%0d", k), {31'd0, tdo}, {31'd0, ID_VALUE[k]});
    end
    check("id_tdo_en_count", en_count, 32);
    check("id_exit1", {28'd0, tap_state}, 32'h1);
    step(1'b1, 1'b0);
    check("upddr_strobe", {31'd0, updateDR}, 32'd1);
    step(1'b0, 1'b0);

    // IR scan of BYPASS with captured-pattern check
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    check("ir_cap_bit0", {31'd0, tdo}, 32'd1);
    check("ir_tdo_en", {31'd0, tdo_en}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, 1'b1);
      if (i < 3) check($sformatf("ir_cap_bit%0d", i + 1), {31'd0, tdo}, 32'd0);
    end
    check("ir_exit1_en", {31'd0, tdo_en}, 32'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("bypass_instr", {28'd0, instruction}, 32'hF);
    check("bypass_sel", {29'd0, select_idcode, select_bypass, select_usercode}, 32'b010);

    // 8-bit bypass DR shift of 10110011 (LSB-first)
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    check("byp_bit0", {31'd0, tdo}, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      exp_bit = {31'd0, TDI_PAT[k-1]};
      step(k == 8, (8'b1011_0011 >> (k - 1)) & 1'b1 ? 1'b1 : 1'b0);
      if (k < 8) begin
        exp_bit = {31'd0, ((8'b1011_0011 >> (k - 1)) & 8'd1) != 8'd0};
        check($sformatf("byp_bit%0d", k), {31'd0, tdo}, exp_bit);
      end
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Five tms=1 edges reach TLR from every state
    for (int s = 0; s < 16; s++) begin
      do_reset();
      load_ir(4'b1111);
      for (int k = 0; k < paths[s].len(); k++) step(paths[s][k] == 8'd49, 1'b0);
      check($sformatf("nav_state%0d", s), {28'd0, tap_state}, {28'd0, targets[s]});
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
      check($sformatf("tlr_state%0d", s), {28'd0, tap_state}, 32'hF);
      check($sformatf("tlr_instr%0d", s), {28'd0, instruction}, 32'h1);
    end

    // Reset on the 3rd Shift-IR bit of 4'b0010
    step(1'b0, 1'b0);
    load_ir(4'b1111);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b1);
    reset = 1'b1;
    step(1'b0, 1'b0);
    check("midrst_state", {28'd0, tap_state}, 32'hF);
    check("midrst_instr", {28'd0, instruction}, 32'h1);
    check("midrst_tdo", {30'd0, tdo, tdo_en}, 32'd0);
    reset = 1'b0;
    step(1'b0, 1'b0);

    // USERCODE load and 32-bit DR shift
    load_ir(4'b0010);
    check("uc_instr", {28'd0, instruction}, 32'h2);
`ifdef TAP_USERCODE_EN
    check("uc_sel", {29'd0, select_idcode, select_bypass, select_usercode}, 32'b001);
`else
    check("uc_sel", {29'd0, select_idcode, select_bypass, select_usercode}, 32'b010);
`endif
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int k = 0; k < 32; k++) begin
`ifdef TAP_USERCODE_EN
      exp_bit = {31'd0, UC_VALUE[k]};
`else
      exp_bit = (k == 0) ? 32'd0 : {31'd0, TDI_PAT[k-1]};
`endif
      check($sformatf("uc_bit%0d", k), {31'd0, tdo}, exp_bit);
      step(k == 31, TDI_PAT[k]);
    end
    check("uc_exit1_en", {31'd0, tdo_en}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
